// File: rtl/oclib_bc_serial_tx.sv
// Transmit half of the 1-bit asynchronous byte-channel link.
// Accepts a byte on ready/valid and sends it LSB first as start/data/stop.
// It then waits for the receiver's toggle-ack before accepting the next byte.
// Optional feature macro: OCLIB_BC_SERIAL_TX_ACK_TIMEOUT_EN (bounded WAIT_ACK with sticky ackTimeout).
module oclib_bc_serial_tx #(
  parameter int unsigned Width            = 8,
  parameter int unsigned BitCycles        = 16,
  parameter int unsigned SyncStages       = 2,
  parameter int unsigned AckTimeoutCycles = 4096
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [Width-1:0] inData,
  input  logic             inValid,
  output logic             inReady,
  output logic             outData,
  input  logic             outAck,
  output logic             ackTimeout
);

  localparam int unsigned CntW = $clog2(BitCycles);
  localparam int unsigned IdxW = $clog2(Width + 1);

  // Reject parameter values the framing cannot support.
  if (Width < 1 || Width > 16 || BitCycles < 2 || SyncStages < 2 || AckTimeoutCycles < 1) begin : gBadParams
    $error("oclib_bc_serial_tx: illegal parameter value");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_ACK} state_t;

  state_t                state, stateNxt;
  logic [CntW-1:0]       bitCnt, bitCntNxt;
  logic [IdxW-1:0]       bitIdx, bitIdxNxt;
  logic [Width-1:0]      shift, shiftNxt;
  logic [SyncStages-1:0] ackSync;
  logic                  ackSeen, ackSeenNxt;
  logic                  outDataNxt, inReadyNxt;
  logic                  ackPending, bitDone, toHit;

  assign ackPending = (ackSync[SyncStages-1] != ackSeen);
  assign bitDone    = (bitCnt == CntW'(BitCycles - 1));

`ifdef OCLIB_BC_SERIAL_TX_ACK_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(AckTimeoutCycles + 1);
  logic [ToW-1:0] toCnt;

  assign toHit = (toCnt == ToW'(AckTimeoutCycles - 1));

  // Count WAIT_ACK cycles without an ack; the flag stays set until reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      toCnt      <= '0;
      ackTimeout <= 1'b0;
    end else begin
      if (state == WAIT_ACK && !ackPending && !toHit) toCnt <= toCnt + ToW'(1);
      else                                            toCnt <= '0;
      if (state == WAIT_ACK && !ackPending && toHit) ackTimeout <= 1'b1;
    end
  end
`else
  assign toHit      = 1'b0;
  assign ackTimeout = 1'b0;
`endif

  // Bring the asynchronous toggle-ack into the clock domain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ackSync <= '0;
    else        ackSync <= {ackSync[SyncStages-2:0], outAck};
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNxt;
  end

  // Next-state, datapath and registered-output next values.
  always_comb begin
    stateNxt   = state;
    bitCntNxt  = bitCnt;
    bitIdxNxt  = bitIdx;
    shiftNxt   = shift;
    ackSeenNxt = ackSeen;
    outDataNxt = 1'b1;
    unique case (state)
      IDLE: begin
        if (inValid && inReady) begin
          shiftNxt  = inData;
          bitCntNxt = '0;
          bitIdxNxt = '0;
          stateNxt  = START;
        end
      end
      START: begin
        outDataNxt = 1'b0;
        if (bitDone) begin
          bitCntNxt = '0;
          stateNxt  = DATA;
        end else begin
          bitCntNxt = bitCnt + CntW'(1);
        end
      end
      DATA: begin
        outDataNxt = shift[0];
        if (bitDone) begin
          bitCntNxt = '0;
          shiftNxt  = shift >> 1;
          bitIdxNxt = bitIdx + IdxW'(1);
          if (bitIdx == IdxW'(Width - 1)) stateNxt = STOP;
        end else begin
          bitCntNxt = bitCnt + CntW'(1);
        end
      end
      STOP: begin
        if (bitDone) begin
          bitCntNxt = '0;
          stateNxt  = WAIT_ACK;
        end else begin
          bitCntNxt = bitCnt + CntW'(1);
        end
      end
      WAIT_ACK: begin
        if (ackPending) begin
          ackSeenNxt = ackSync[SyncStages-1];
          stateNxt   = IDLE;
        end else if (toHit) begin
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
    inReadyNxt = (stateNxt == IDLE);
  end

  // Datapath and output registers; outData lags the state by one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bitCnt  <= '0;
      bitIdx  <= '0;
      shift   <= '0;
      ackSeen <= 1'b0;
      outData <= 1'b1;
      inReady <= 1'b0;
    end else begin
      bitCnt  <= bitCntNxt;
      bitIdx  <= bitIdxNxt;
      shift   <= shiftNxt;
      ackSeen <= ackSeenNxt;
      outData <= outDataNxt;
      inReady <= inReadyNxt;
    end
  end

endmodule

// File: tb/tb_oclib_bc_serial_tx.sv
// Directed bench for oclib_bc_serial_tx (Width=8, BitCycles=4, SyncStages=2, AckTimeoutCycles=32).
module tb_oclib_bc_serial_tx;

  logic       clock;
  logic       reset;
  logic [7:0] inData;
  logic       inValid;
  logic       inReady;
  logic       outData;
  logic       outAck;
  logic       ackTimeout;

  int nChecks = 0;
  int nErrors = 0;

  oclib_bc_serial_tx #(
    .Width(8), .BitCycles(4), .SyncStages(2), .AckTimeoutCycles(32)
  ) dut (
    .clock(clock), .reset(reset), .inData(inData), .inValid(inValid),
    .inReady(inReady), .outData(outData), .outAck(outAck), .ackTimeout(ackTimeout)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for inReady, present a byte, and confirm it was taken.
  task automatic offer(input logic [7:0] b, input string tag);
    int n = 0;
    while (!inReady && n < 200) begin
      @(negedge clock);
      n++;
    end
    check({tag, ".rdy"}, 32'(inReady), 32'd1);
    inValid = 1'b1;
    inData  = b;
    @(negedge clock);
    check({tag, ".acc"}, 32'(inReady), 32'd0);
    inValid = 1'b0;
  endtask

  // Entered at the first negedge after the accept edge (k=0); returns at k=40.
  task automatic captureFrame(input logic [7:0] b, input int ackK, input bit bp, input string tag);
    logic [40:0] s;
    logic        e;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) @(negedge clock);
      s[k] = outData;
      if (k == ackK) outAck = ~outAck;
      if (bp) begin
        inValid = 1'b1;
        inData  = 8'($urandom);
      end
    end
    check({tag, ".pre"}, 32'(s[0]), 32'd1);
    for (int j = 0; j < 10; j++) begin
      e = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
      check($sformatf("%s.bit%0d", tag, j), 32'(s[1+4*j +: 4]), 32'({4{e}}));
    end
  endtask

  // Count negedges until inReady rises (bounded).
  task automatic waitReady(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!inReady && n < 2000);
  endtask

  initial begin
    int n;
    int cnt;
    reset   = 1'b0;
    inValid = 1'b0;
    inData  = 8'h00;
    outAck  = 1'b0;

    // Reset behaviour
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check($sformatf("rst.outData%0d", i), 32'(outData), 32'd1);
      check($sformatf("rst.inReady%0d", i), 32'(inReady), 32'd0);
    end
    reset = 1'b1;
    @(negedge clock);
    check("rel.inReady", 32'(inReady), 32'd1);
    check("rel.ackTimeout", 32'(ackTimeout), 32'd0);
    check("rel.outData", 32'(outData), 32'd1);

    // Single byte 0xA5, ack 10 cycles after the stop bit
    offer(8'hA5, "a5");
    captureFrame(8'hA5, -1, 1'b0, "a5");
    repeat (10) @(negedge clock);
    check("a5.waiting", 32'(inReady), 32'd0);
    outAck = ~outAck;
    waitReady(n);
    check("a5.ackLat", 32'(n), 32'd3);

    // Back-to-back 0x00 then 0xFF with mid-stop-bit ack
    offer(8'h00, "b1");
    captureFrame(8'h00, 38, 1'b0, "b1");
    inValid = 1'b1;
    inData  = 8'hFF;
    @(negedge clock);
    check("b2b.rdy", 32'(inReady), 32'd1);
    check("b2b.gap1", 32'(outData), 32'd1);
    @(negedge clock);
    check("b2b.acc", 32'(inReady), 32'd0);
    inValid = 1'b0;
    captureFrame(8'hFF, 38, 1'b0, "b2");
    @(negedge clock);
    check("b2.rdy", 32'(inReady), 32'd1);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (!outData) cnt++;
    end
    check("b2.noDup", 32'(cnt), 32'd0);

    // Backpressure: inData churns while a frame is in flight
    offer(8'h5A, "bp");
    captureFrame(8'h5A, -1, 1'b1, "bp");
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (inReady) cnt++;
      inValid = 1'b1;
      inData  = 8'($urandom);
    end
    check("bp.noAccept", 32'(cnt), 32'd0);
    inData = 8'hC3;
    outAck = ~outAck;
    waitReady(n);
    check("bp.ackLat", 32'(n), 32'd3);
    @(negedge clock);
    check("bp2.acc", 32'(inReady), 32'd0);
    inValid = 1'b0;
    captureFrame(8'hC3, 38, 1'b0, "bp2");
    @(negedge clock);
    check("bp2.rdy", 32'(inReady), 32'd1);

    // Reset during data bit 3 (0xF0 keeps the line low there)
    offer(8'hF0, "mr");
    repeat (18) @(negedge clock);
    check("mr.bit3", 32'(outData), 32'd0);
    reset  = 1'b0;
    outAck = 1'b0;
    #1;
    check("mr.asyncHigh", 32'(outData), 32'd1);
    check("mr.inReady", 32'(inReady), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("mr.relReady", 32'(inReady), 32'd1);
    offer(8'h3C, "r3c");
    captureFrame(8'h3C, 38, 1'b0, "r3c");
    @(negedge clock);
    check("r3c.rdy", 32'(inReady), 32'd1);

    // Ack never arrives
    offer(8'h81, "to");
    captureFrame(8'h81, -1, 1'b0, "to");
`ifdef OCLIB_BC_SERIAL_TX_ACK_TIMEOUT_EN
    n = 0;
    while (!ackTimeout && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("to.lat", 32'(n), 32'd32);
    @(negedge clock);
    check("to.sticky", 32'(ackTimeout), 32'd1);
    check("to.rdy", 32'(inReady), 32'd1);
    offer(8'h42, "ta");
    captureFrame(8'h42, 38, 1'b0, "ta");
    @(negedge clock);
    check("ta.rdy", 32'(inReady), 32'd1);
    check("ta.sticky", 32'(ackTimeout), 32'd1);
`else
    cnt = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clock);
      if (inReady) cnt++;
      if (ackTimeout) cnt++;
    end
    check("to.stuck", 32'(cnt), 32'd0);
    outAck = ~outAck;
    waitReady(n);
    check("to.release", 32'(n), 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/oclib_bc_serial_tx.md
# oclib_bc_serial_tx

Transmit half of the 1-bit asynchronous byte-channel link. It accepts bytes on a ready/valid interface, typically from a byte-channel buffer or the byte-channel adapter's synchronous side. Each byte goes out as a self-framed serial frame on a single wire: start bit, data LSB first, then stop bit. The block then waits for the far end's toggle-ack before taking the next byte, which gives the link end-to-end flow control across clock domains.

## Interface
- Width, 8: data bits per frame; legal range 1..16.
- BitCycles, 16: clock cycles each serial bit is held; minimum 2.
- SyncStages, 2: flops in the `outAck` synchronizer; minimum 2.
- AckTimeoutCycles, 4096: cycles allowed in WAIT_ACK; used only when the timeout feature is compiled in.

Ports:
- clock  input  1  sole clock; all flops rise on it.
- reset  input  1  asynchronous, active-low (0 = in reset); asserts asynchronously, deasserts synchronously to `clock` upstream of this block.
- inData  input  Width  byte to send; sampled on accept.
- inValid  input  1  `inData` valid.
- inReady  output  1  block can accept; registered.
- outData  output  1  serial line; idles high.
- outAck  input  1  toggle-ack from receiver; asynchronous to `clock`.
- ackTimeout  output  1  sticky error flag: ack never arrived.

## Operation
- FSM states are IDLE, START, DATA, STOP and WAIT_ACK.
- In reset:
  - State is IDLE, `outData`=1 and `inReady`=0, `ackTimeout`=0.
  - `ackSeen`=0, all counters are 0, and the synchronizer flops are 0.
- First cycle after reset release: `inReady`=1.
- IDLE: `inReady`=1. On `inValid && inReady`:
  - capture `inData` into the shift register;
  - drop `inReady` to 0 on the next edge;
  - go to START.
- START: `outData`=0 for BitCycles cycles, then go to DATA.
- DATA: `outData`=shift[0] for BitCycles cycles per bit.
  - The shift register shifts right after each bit.
  - After Width bits, go to STOP.
- STOP: `outData`=1 for BitCycles cycles, then go to WAIT_ACK.
- WAIT_ACK: `outData`=1. When synchronized ack != `ackSeen`:
  - set `ackSeen` to the synchronized ack;
  - go to IDLE, with `inReady`=1 on the following cycle.
- Early ack: a toggle that arrives during START, DATA or STOP is held in the synchronizer. It is honoured on the first WAIT_ACK cycle, so a receiver that acks at the stop-bit midpoint is legal.
- Double toggle: two toggles before WAIT_ACK cancel each other. This is a receiver protocol violation and is not detected.
- Counters:
  - Bit-cycle counter is $clog2(BitCycles) bits; it counts 0..BitCycles-1 and wraps to 0 on each bit boundary.
  - Bit index is $clog2(Width+1) bits.
- `inData` and `inValid` are ignored outside IDLE.
- Reset mid-frame aborts immediately:
  - `outData` returns high asynchronously;
  - the partial frame is lost;
  - the receiver's framing recovers on the next start bit.

## Timing
- Accept-to-start latency: accept at edge N; `outData` falls after edge N+1.
- Frame length: (Width+2)*BitCycles cycles, from the first START cycle through the last STOP cycle.
- Minimum byte period: (Width+2)*BitCycles + 1 WAIT_ACK cycle + 1 IDLE cycle, with the ack already pending.
- Ack path latency: SyncStages cycles from an `outAck` edge to WAIT_ACK seeing it.
- `outData` and `inReady` come straight from flops; neither has a combinational path from any input.

## Configuration
- Macro: `OCLIB_BC_SERIAL_TX_ACK_TIMEOUT_EN`.
- Defined:
  - A cycle counter runs in WAIT_ACK.
  - When it reaches AckTimeoutCycles, the FSM goes to IDLE and `ackTimeout` sets to 1; `ackSeen` is unchanged.
  - `ackTimeout` stays set until reset.
- Undefined:
  - No counter is built and `ackTimeout` is tied 0.
  - WAIT_ACK waits indefinitely.
  - AckTimeoutCycles is ignored.

## Test plan
- Reset: hold reset=0 for 5 cycles, then release. Required: `outData`=1 and `inReady`=0 during reset; `inReady`=1 on the first cycle after release; `ackTimeout`=0.
- Single byte: BitCycles=4, send 0xA5, toggle `outAck` 10 cycles after the stop bit ends. Required:
  - `outData` carries 0,1,0,1,0,0,1,0,1,1, each held exactly 4 cycles, starting after the cycle following accept;
  - `inReady` returns exactly SyncStages+1 cycles after the ack edge.
- Back-to-back with early ack: send 0x00 then 0xFF, with the receiver toggling ack mid-stop-bit. Required:
  - the second START begins 2 cycles after the first STOP ends;
  - no byte is dropped or duplicated.
- Backpressure: hold `inValid`=1 with `inData` changing each cycle during a frame. Required: only the value present at the accept cycle is transmitted; the next accept happens only after the ack.
- Reset mid-frame: assert reset during data bit 3. Required:
  - `outData`=1 asynchronously, in the same cycle;
  - after release the FSM is in IDLE and `inReady`=1;
  - a fresh 0x3C then transmits correctly.
- Timeout (macro defined, AckTimeoutCycles=32): send one byte and never toggle ack. Required:
  - `ackTimeout` rises 32 cycles after WAIT_ACK entry and stays high;
  - `inReady`=1 the cycle after;
  - with the macro undefined, `inReady` stays 0 for more than 1000 cycles.
